// File: rtl/system_worker_ocm_copy_master_if.sv
// Avalon-MM bus on the OCM's second slave port: the copy master drives the request side,
// and the memory returns readdata one clock-enabled cycle after a read.
interface system_worker_ocm_copy_master_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address,
    output byteenable,
    output chipselect,
    output write,
    output writedata,
    output clken,
    input  readdata
  );

  modport slave (
    input  address,
    input  byteenable,
    input  chipselect,
    input  write,
    input  writedata,
    input  clken,
    output readdata
  );
endinterface

// File: rtl/system_worker_ocm_copy_master.sv
// OCM copy/fill engine: copy costs 3 cycles per word, fill 1; done arrives 3n+2 (copy) or n+2 (fill) cycles after start.
// hold freezes every register and gates the OCM through clken; there is no other backpressure.
module system_worker_ocm_copy_master #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            mode,
  input  logic [ADDR_W-1:0]               src_addr,
  input  logic [ADDR_W-1:0]               dst_addr,
  input  logic [LEN_W-1:0]                count,
  input  logic [DATA_W-1:0]               fill_value,
  input  logic                            hold,
  output logic                            busy,
  output logic                            done,
  output logic [DATA_W-1:0]               sum,
  system_worker_ocm_copy_master_if.master ocm
);

  localparam int CNT_W     = ADDR_W + 1;
  localparam int MAX_WORDS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_FW,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  n_start;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;

  always_comb begin
    n_start = (32'(count) > 32'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : CNT_W'(count);
  end

  // Bus registers are loaded from the current state, so each state's bus cycle
  // appears on the pins one cycle after the state itself.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    n_d     = n_q;
    fill_d  = fill_q;
    sum_d   = sum_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_d    = cs_q;
    wr_d    = wr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          fill_d = fill_value;
          n_d    = n_start;
          sum_d  = '0;
          busy_d = 1'b1;
          if (n_start == '0) begin
            state_d = S_DONE;
          end else if (mode) begin
            state_d = S_FW;
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        addr_d  = src_q;
        cs_d    = 1'b1;
        wr_d    = 1'b0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = S_WR;
      end

      // The read address left the registers during WAIT, so the word is on
      // readdata now; it is taken straight into the write-data register.
      S_WR: begin
        addr_d  = dst_q;
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        wdata_d = ocm.readdata;
        sum_d   = sum_q + ocm.readdata;
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        n_d     = n_q - CNT_W'(1);
        state_d = (n_q == CNT_W'(1)) ? S_DONE : S_RD;
      end

      S_FW: begin
        addr_d  = dst_q;
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        wdata_d = fill_q;
        sum_d   = sum_q + fill_q;
        dst_d   = dst_q + ADDR_W'(1);
        n_d     = n_q - CNT_W'(1);
        state_d = (n_q == CNT_W'(1)) ? S_DONE : S_FW;
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      n_q     <= '0;
      fill_q  <= '0;
      sum_q   <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (!hold) begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      fill_q  <= fill_d;
      sum_q   <= sum_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign sum            = sum_q;
  assign ocm.address    = addr_q;
  assign ocm.byteenable = '1;
  assign ocm.chipselect = cs_q;
  assign ocm.write      = wr_q;
  assign ocm.writedata  = wdata_q;
  assign ocm.clken      = ~hold;

  a_busy_done_excl : assert property (@(posedge clk) disable iff (!reset_n) !(busy_q && done_q));
  a_write_needs_cs : assert property (@(posedge clk) disable iff (!reset_n) wr_q |-> cs_q);

endmodule

// File: tb/tb_system_worker_ocm_copy_master.sv
// Randomised and directed bench for the OCM copy master: a behavioural OCM answers the bus,
// a word-level reference model predicts memory, sum and timing, and a monitor scores each done pulse.
module tb_system_worker_ocm_copy_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [6:0]  src_addr;
  logic [6:0]  dst_addr;
  logic [7:0]  count;
  logic [31:0] fill_value;
  logic        hold;
  logic        busy;
  logic        done;
  logic [31:0] sum;

  system_worker_ocm_copy_master_if #(.ADDR_W(7), .DATA_W(32)) ocm_bus ();

  system_worker_ocm_copy_master #(.ADDR_W(7), .DATA_W(32), .LEN_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .count      (count),
    .fill_value (fill_value),
    .hold       (hold),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .ocm        (ocm_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port OCM, read latency 1, frozen when clken is low.
  logic [31:0] mem [128];
  logic [31:0] rdata_q;
  logic        pl_en = 1'b0;
  logic [6:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign ocm_bus.readdata = rdata_q;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ocm_bus.clken && ocm_bus.chipselect) begin
      if (ocm_bus.write) begin
        for (int b = 0; b < 4; b++) begin
          if (ocm_bus.byteenable[b]) mem[ocm_bus.address][8*b +: 8] <= ocm_bus.writedata[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[ocm_bus.address];
      end
    end
  end

  typedef struct {
    int          start_cyc;
    int          lat;
    int          writes;
    int          cs_cnt;
    logic [31:0] sum;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [128];
  int          checks = 0;
  int          errors = 0;
  bit          mon_flush = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int mem_diff();
    int nd = 0;
    for (int i = 0; i < 128; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (nd == 0) $display("  first differing word %0d: ocm 0x%0h model 0x%0h", i, mem[i], ref_mem[i]);
        nd++;
      end
    end
    return nd;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  // Reference: words move strictly ascending with wrap, so overlapping copies propagate.
  task automatic issue(input logic m, input logic [6:0] s, input logic [6:0] d,
                       input logic [7:0] c, input logic [31:0] f, input int hold_cyc);
    exp_t        e;
    int          n;
    logic [31:0] w;
    logic [31:0] acc;
    n   = (int'(c) > 128) ? 128 : int'(c);
    acc = 32'd0;
    for (int i = 0; i < n; i++) begin
      w = m ? f : ref_mem[(int'(s) + i) % 128];
      ref_mem[(int'(d) + i) % 128] = w;
      acc = acc + w;
    end
    e.lat    = ((n == 0) ? 2 : (m ? n + 2 : 3 * n + 2)) + hold_cyc;
    e.writes = n;
    e.cs_cnt = m ? n : 2 * n;
    e.sum    = acc;
    start      = 1'b1;
    mode       = m;
    src_addr   = s;
    dst_addr   = d;
    count      = c;
    fill_value = f;
    e.start_cyc = cyc;
    sbq.push_back(e);
    step();
    start      = 1'b0;
    mode       = 1'($urandom);
    src_addr   = 7'($urandom);
    dst_addr   = 7'($urandom);
    count      = 8'($urandom);
    fill_value = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (sbq.size() != 0 && k < budget) begin
      step();
      k++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, %0d command(s) outstanding", budget, sbq.size());
      sbq.delete();
    end
    step();
  endtask

  task automatic monitor();
    int   cs_c = 0;
    int   wr_c = 0;
    int   bz_c = 0;
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_flush) begin
        cs_c = 0;
        wr_c = 0;
        bz_c = 0;
        mon_flush = 1'b0;
      end
      if (ocm_bus.clken && ocm_bus.chipselect) cs_c++;
      if (ocm_bus.clken && ocm_bus.chipselect && ocm_bus.write) wr_c++;
      if (busy) bz_c++;
      if (done && !done_prev) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("done_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          chk("sum", sum, e.sum);
          chk("write_count", 32'(wr_c), 32'(e.writes));
          chk("cs_cycles", 32'(cs_c), 32'(e.cs_cnt));
          chk("busy_cycles", 32'(bz_c), 32'(e.lat - 1));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("byteenable", 32'(ocm_bus.byteenable), 32'hF);
          chk("ocm_contents", 32'(mem_diff()), 32'd0);
        end
        cs_c = 0;
        wr_c = 0;
        bz_c = 0;
      end
      done_prev = done;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_sum"}, sum, 32'd0);
    chk({tag, "_address"}, 32'(ocm_bus.address), 32'd0);
    chk({tag, "_chipselect"}, 32'(ocm_bus.chipselect), 32'd0);
    chk({tag, "_write"}, 32'(ocm_bus.write), 32'd0);
    chk({tag, "_writedata"}, ocm_bus.writedata, 32'd0);
    chk({tag, "_byteenable"}, 32'(ocm_bus.byteenable), 32'hF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0]  a0;
    logic        cs0, w0, b0;
    logic [31:0] wd0;
    int          k;

    reset_n = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    count = '0; fill_value = '0; hold = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    chk("reset_clken", 32'(ocm_bus.clken), 32'd1);
    step();
    step();
    reset_n = 1'b1;
    step();

    fork
      monitor();
    join_none

    for (int i = 0; i < 128; i++) preload(7'(i), $urandom);

    // Plain copy of four known words.
    for (int i = 0; i < 4; i++) preload(7'(10 + i), 32'(i + 1));
    issue(1'b0, 7'd10, 7'd40, 8'd4, 32'h0, 0);
    wait_idle(200);

    // Fill across the top of memory.
    issue(1'b1, 7'd0, 7'd126, 8'd4, 32'hA5A5A5A5, 0);
    wait_idle(200);

    // Zero-length command.
    issue(1'($urandom), 7'($urandom), 7'($urandom), 8'd0, $urandom, 0);
    wait_idle(200);

    // Five hold cycles during the second word's WAIT of a 3-word copy.
    issue(1'b0, 7'd50, 7'd90, 8'd3, 32'h0, 5);
    repeat (4) step();
    hold = 1'b1;
    a0 = ocm_bus.address; cs0 = ocm_bus.chipselect; w0 = ocm_bus.write;
    wd0 = ocm_bus.writedata; b0 = busy;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_clken", 32'(ocm_bus.clken), 32'd0);
      chk("hold_ctl", 32'({ocm_bus.address, ocm_bus.chipselect, ocm_bus.write, busy}),
          32'({a0, cs0, w0, b0}));
      chk("hold_wdata", ocm_bus.writedata, wd0);
    end
    hold = 1'b0;
    wait_idle(200);

    // Overlapping copy propagates the first word.
    preload(7'd0, 32'd7);
    issue(1'b0, 7'd0, 7'd1, 8'd3, 32'h0, 0);
    wait_idle(200);

    // Oversized count saturates to the whole memory.
    issue(1'b1, 7'($urandom), 7'($urandom), 8'd200, $urandom, 0);
    wait_idle(400);
    issue(1'b0, 7'($urandom), 7'($urandom), 8'd255, 32'h0, 0);
    wait_idle(1000);

    // A start pulse while busy must be ignored.
    issue(1'b0, 7'd70, 7'd100, 8'd6, 32'h0, 0);
    repeat (3) step();
    start = 1'b1; mode = 1'b1; dst_addr = 7'd30; count = 8'd10; fill_value = 32'hDEADBEEF;
    step();
    start = 1'b0;
    wait_idle(200);
    repeat (30) step();
    chk("ignored_start_busy", 32'(busy), 32'd0);
    chk("ignored_start_mem", 32'(mem_diff()), 32'd0);

    for (int t = 0; t < 25; t++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
      issue(1'($urandom), 7'($urandom), 7'($urandom), c, $urandom, 0);
      wait_idle(1000);
    end

    // Reset after the first write of a 4-word copy.
    start = 1'b1; mode = 1'b0; src_addr = 7'd20; dst_addr = 7'd60; count = 8'd4;
    step();
    start = 1'b0;
    k = 0;
    while (!(ocm_bus.chipselect && ocm_bus.write) && k < 50) begin
      step();
      k++;
    end
    if (k == 50) begin
      checks++;
      errors++;
      $display("FAIL first_write_timeout: no write seen within 50 cycles");
    end
    step();
    ref_mem[60] = ref_mem[20];
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    step();
    reset_n = 1'b1;
    mon_flush = 1'b1;
    repeat (20) step();
    chk("midreset_no_restart", 32'(busy), 32'd0);
    chk("midreset_mem", 32'(mem_diff()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
